// File: rtl/pyrm_fetch_queue_block.sv
// RISC-V fetch stage: sequential fetch, JAL/branch predecode, QDEPTH-entry {pc, inst} queue.
// Optional perf counters under `PYRM_FETCH_PERF_CNT_EN`.
module pyrm_fetch_queue_block #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter int              IMEM_AW  = 12,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               reset_pyri,
  input  logic [XLEN-1:0]    branch_pc_pyri,
  input  logic               branch_pc_valid_pyri,
  output logic               branch_pc_retry_pyro,
  output logic               imem_req_pyro,
  output logic [IMEM_AW-1:0] imem_addr_pyro,
  input  logic [ILEN-1:0]    imem_data_pyri,
  output logic [XLEN-1:0]    pc_pyro,
  output logic               pc_valid_pyro,
  input  logic               pc_retry_pyri,
  output logic [ILEN-1:0]    inst_pyro,
  output logic               inst_valid_pyro,
`ifdef PYRM_FETCH_PERF_CNT_EN
  output logic [63:0]        fetched_cnt_pyro,
  output logic [63:0]        br_stall_cnt_pyro,
`endif
  input  logic               inst_retry_pyri
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_nx;
  logic              inflight, inflight_nx;
  logic [XLEN-1:0]   inflight_pc;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   q_pc   [QDEPTH];
  logic [ILEN-1:0]   q_inst [QDEPTH];

  logic              head_valid, pop, flush, req, push, is_jal, is_br;
  logic [CW:0]       occupancy;
  logic [6:0]        opcode;
  logic [XLEN-1:0]   jal_off;

  assign head_valid = (count != '0) && !reset_pyri;
  assign pop        = head_valid && !(pc_retry_pyri | inst_retry_pyri);
  assign flush      = branch_pc_valid_pyri && (state == RUN);
  // Credit check uses registered occupancy only, so a response can never hit a full queue.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req        = (state == RUN) && !reset_pyri && (occupancy < (CW+1)'(QDEPTH));
  assign push       = inflight && !flush;
  assign opcode     = imem_data_pyri[6:0];
  assign is_jal     = push && (opcode == OP_JAL);
  assign is_br      = push && ((opcode == OP_BRANCH) || (opcode == OP_JALR));
  assign jal_off    = {{(XLEN-21){imem_data_pyri[31]}}, imem_data_pyri[31], imem_data_pyri[19:12],
                       imem_data_pyri[20], imem_data_pyri[30:21], 1'b0};

  assign branch_pc_retry_pyro = 1'b0;
  assign imem_req_pyro        = req;
  assign imem_addr_pyro       = fetch_pc[IMEM_AW+1:2];
  assign pc_valid_pyro        = head_valid;
  assign inst_valid_pyro      = head_valid;
  assign pc_pyro              = head_valid ? q_pc[rd_ptr]   : '0;
  assign inst_pyro            = head_valid ? q_inst[rd_ptr] : '0;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    inflight_nx = req;
    if (req)    fetch_pc_nx = fetch_pc + XLEN'(4);
    if (is_jal) begin
      fetch_pc_nx = inflight_pc + jal_off;
      inflight_nx = 1'b0;
    end
    if (is_br) begin
      state_nx    = BR_WAIT;
      inflight_nx = 1'b0;
    end
    if ((state == BR_WAIT) && branch_pc_valid_pyri) begin
      fetch_pc_nx = branch_pc_pyri;
      state_nx    = RUN;
    end
    if (flush) begin
      fetch_pc_nx = branch_pc_pyri;
      inflight_nx = 1'b0;
      state_nx    = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_pyri) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      inflight <= inflight_nx;
      if (req) inflight_pc <= fetch_pc;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  // NOTE: queue storage carries no reset; occupancy and the output gating make stale entries invisible.
  always_ff @(posedge clk) begin
    if (!reset_pyri && push) begin
      q_pc[wr_ptr]   <= inflight_pc;
      q_inst[wr_ptr] <= imem_data_pyri;
    end
  end

`ifdef PYRM_FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset_pyri) begin
      fetched_cnt_pyro  <= '0;
      br_stall_cnt_pyro <= '0;
    end else begin
      if (pop && (fetched_cnt_pyro != '1))
        fetched_cnt_pyro <= fetched_cnt_pyro + 64'd1;
      if ((state == BR_WAIT) && (br_stall_cnt_pyro != '1))
        br_stall_cnt_pyro <= br_stall_cnt_pyro + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pyrm_fetch_queue_block.sv
// Scoreboard bench for pyrm_fetch_queue_block: directed programs, monitor compares every dequeue.
module tb_pyrm_fetch_queue_block;
  localparam int XLEN = 64, ILEN = 32, QDEPTH = 4, IMEM_AW = 12;

  logic               clk = 1'b0;
  logic               reset_pyri;
  logic [XLEN-1:0]    branch_pc_pyri;
  logic               branch_pc_valid_pyri;
  logic               branch_pc_retry_pyro;
  logic               imem_req_pyro;
  logic [IMEM_AW-1:0] imem_addr_pyro;
  logic [ILEN-1:0]    imem_data_pyri;
  logic [XLEN-1:0]    pc_pyro;
  logic               pc_valid_pyro;
  logic               pc_retry_pyri;
  logic [ILEN-1:0]    inst_pyro;
  logic               inst_valid_pyro;
  logic               inst_retry_pyri;

  pyrm_fetch_queue_block #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .reset_pyri(reset_pyri),
    .branch_pc_pyri(branch_pc_pyri), .branch_pc_valid_pyri(branch_pc_valid_pyri),
    .branch_pc_retry_pyro(branch_pc_retry_pyro),
    .imem_req_pyro(imem_req_pyro), .imem_addr_pyro(imem_addr_pyro), .imem_data_pyri(imem_data_pyri),
    .pc_pyro(pc_pyro), .pc_valid_pyro(pc_valid_pyro), .pc_retry_pyri(pc_retry_pyri),
    .inst_pyro(inst_pyro), .inst_valid_pyro(inst_valid_pyro), .inst_retry_pyri(inst_retry_pyri)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) if (imem_req_pyro) imem_data_pyri <= mem[imem_addr_pyro];

  typedef struct packed { logic [63:0] pc; logic [31:0] inst; } item_t;
  item_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_item(input logic [63:0] pc, input logic [31:0] inst);
    item_t it;
    it.pc = pc;
    it.inst = inst;
    sb.push_back(it);
  endtask

  task automatic expect_nops(input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) expect_item(base + 64'(4 * k), 32'h13);
  endtask

  // Monitor: every head that will pop at the next edge is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset_pyri && pc_valid_pyro && !pc_retry_pyri && !inst_retry_pyri && !branch_pc_valid_pyri) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got pc %h, expected nothing", pc_pyro);
      end else begin
        item_t e;
        e = sb.pop_front();
        check("deq_pc", pc_pyro, e.pc);
        check("deq_inst", 64'(inst_pyro), 64'(e.inst));
        check("inst_valid", 64'(inst_valid_pyro), 64'd1);
      end
    end
  end

  task automatic start_test();
    @(posedge clk) #1;
    reset_pyri = 1'b1;
    branch_pc_valid_pyri = 1'b0;
    pc_retry_pyri = 1'b0;
    inst_retry_pyri = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4096; i++) mem[i] = 32'h13;
    sb.delete();
  endtask

  task automatic release_reset();
    @(posedge clk) #1 reset_pyri = 1'b0;
  endtask

  task automatic drain_wait();
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    #1 inst_retry_pyri = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_pyri = 1'b1;
    branch_pc_pyri = '0;
    branch_pc_valid_pyri = 1'b0;
    pc_retry_pyri = 1'b0;
    inst_retry_pyri = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h13;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 64'(imem_req_pyro), 64'd0);
    check("rst_pc_valid", 64'(pc_valid_pyro), 64'd0);
    check("rst_inst_valid", 64'(inst_valid_pyro), 64'd0);
    check("rst_pc", pc_pyro, 64'd0);
    check("rst_inst", 64'(inst_pyro), 64'd0);
    check("br_retry", 64'(branch_pc_retry_pyro), 64'd0);

    // Sequential NOP stream and first-fetch latency
    expect_nops(64'h8000_0000, 8);
    release_reset();
    @(negedge clk);
    check("t1_req0", 64'(imem_req_pyro), 64'd1);
    check("t1_addr0", 64'(imem_addr_pyro), 64'h000);
    check("t1_valid0", 64'(pc_valid_pyro), 64'd0);
    @(negedge clk);
    check("t1_addr1", 64'(imem_addr_pyro), 64'h001);
    check("t1_valid1", 64'(pc_valid_pyro), 64'd0);
    @(negedge clk);
    check("t1_first_valid", 64'(pc_valid_pyro), 64'd1);
    check("t1_first_pc", pc_pyro, 64'h8000_0000);
    drain_wait();

    // JAL x0,16 at 0x80000008: 0x8000000C squashed, continue at 0x80000018
    start_test();
    mem[2] = 32'h0100_006F;
    expect_nops(64'h8000_0000, 2);
    expect_item(64'h8000_0008, 32'h0100_006F);
    expect_nops(64'h8000_0018, 3);
    release_reset();
    drain_wait();

    // Branch at 0x80000004: BR_WAIT, then redirect to 0x80000100
    start_test();
    mem[1] = 32'h0000_0063;
    expect_item(64'h8000_0000, 32'h13);
    expect_item(64'h8000_0004, 32'h0000_0063);
    expect_nops(64'h8000_0100, 3);
    release_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_brwait_noreq", 64'(imem_req_pyro), 64'd0);
    end
    @(posedge clk) #1;
    branch_pc_pyri = 64'h8000_0100;
    branch_pc_valid_pyri = 1'b1;
    @(posedge clk) #1 branch_pc_valid_pyri = 1'b0;
    @(negedge clk);
    check("t3_req_after_br", 64'(imem_req_pyro), 64'd1);
    check("t3_addr_after_br", 64'(imem_addr_pyro), 64'h040);
    drain_wait();

    // inst_retry held 10 cycles: queue fills to QDEPTH, fetch stops, then drains in order
    start_test();
    inst_retry_pyri = 1'b1;
    expect_nops(64'h8000_0000, 6);
    release_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_full_noreq", 64'(imem_req_pyro), 64'd0);
    check("t4_head_valid", 64'(pc_valid_pyro), 64'd1);
    check("t4_head_pc", pc_pyro, 64'h8000_0000);
    @(posedge clk) #1 inst_retry_pyri = 1'b0;
    drain_wait();

    // Redirect in RUN with 3 entries queued and a response in flight
    start_test();
    pc_retry_pyri = 1'b1;
    release_reset();
    repeat (4) @(posedge clk);
    #1;
    check("t5_pre_valid", 64'(pc_valid_pyro), 64'd1);
    check("t5_pre_pc", pc_pyro, 64'h8000_0000);
    check("t5_pre_noreq", 64'(imem_req_pyro), 64'd0);
    branch_pc_pyri = 64'h8000_0200;
    branch_pc_valid_pyri = 1'b1;
    @(posedge clk) #1;
    branch_pc_valid_pyri = 1'b0;
    check("t5_flush_pc_valid", 64'(pc_valid_pyro), 64'd0);
    check("t5_flush_inst_valid", 64'(inst_valid_pyro), 64'd0);
    check("t5_redir_req", 64'(imem_req_pyro), 64'd1);
    check("t5_redir_addr", 64'(imem_addr_pyro), 64'h080);
    expect_nops(64'h8000_0200, 3);
    pc_retry_pyri = 1'b0;
    drain_wait();

    // Reset while in BR_WAIT with a full queue
    start_test();
    mem[3] = 32'h0000_0063;
    inst_retry_pyri = 1'b1;
    release_reset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t6_brwait_noreq", 64'(imem_req_pyro), 64'd0);
    check("t6_full_valid", 64'(pc_valid_pyro), 64'd1);
    check("t6_full_pc", pc_pyro, 64'h8000_0000);
    @(posedge clk) #1 reset_pyri = 1'b1;
    @(negedge clk);
    check("t6_rst_req", 64'(imem_req_pyro), 64'd0);
    check("t6_rst_valid", 64'(pc_valid_pyro), 64'd0);
    expect_nops(64'h8000_0000, 3);
    expect_item(64'h8000_000C, 32'h0000_0063);
    @(posedge clk) #1 reset_pyri = 1'b0;
    @(negedge clk);
    check("t6_post_valid", 64'(pc_valid_pyro), 64'd0);
    check("t6_post_req", 64'(imem_req_pyro), 64'd1);
    check("t6_post_addr", 64'(imem_addr_pyro), 64'h000);
    inst_retry_pyri = 1'b0;
    drain_wait();
    @(negedge clk);
    check("t6_end_brwait_noreq", 64'(imem_req_pyro), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pyrm_fetch_queue_block.md
Name: pyrm_fetch_queue_block

Overview:
Parametrised next-generation RISC-V fetch stage. It issues sequential fetches to a 1-cycle-latency instruction memory and predecodes each returned word. JAL redirects locally; BRANCH/JALR stall fetch until the branch PC arrives. Fetched {pc, inst} pairs are buffered in a QDEPTH-entry queue that feeds decode through the valid/retry handshake.

Parameters:
XLEN, 64, PC and branch-target width
ILEN, 32, instruction width (fixed 32, no compressed)
QDEPTH, 4, fetch queue entries (power of 2, >=2)
IMEM_AW, 12, instruction-memory word-address bits (address = pc[IMEM_AW+1:2])
RESET_PC, 64'h80000000, PC loaded on reset

Ports:
clk  in  1  clock, all state on posedge
reset_pyri  in  1  synchronous, active-high reset
branch_pc_pyri  in  XLEN  resolved branch/redirect target
branch_pc_valid_pyri  in  1  target valid this cycle
branch_pc_retry_pyro  out  1  always 0; a redirect is accepted in the cycle it is presented
imem_req_pyro  out  1  fetch request this cycle
imem_addr_pyro  out  IMEM_AW  word address of the request
imem_data_pyri  in  ILEN  instruction word, valid exactly 1 cycle after the request
pc_pyro  out  XLEN  PC of the queue head
pc_valid_pyro  out  1  queue non-empty
pc_retry_pyri  in  1  downstream PC stall
inst_pyro  out  ILEN  instruction at the queue head
inst_valid_pyro  out  1  queue non-empty (same as pc_valid_pyro)
inst_retry_pyri  in  1  downstream instruction stall

Behaviour:
- Reset: state=RUN, fetch_pc=RESET_PC, queue empty, inflight=0.
  - Outputs: pc_valid_pyro=inst_valid_pyro=0, pc_pyro=0, inst_pyro=0, imem_req_pyro=0 during reset.
- Request issue:
  - imem_req_pyro=1 iff state==RUN, not in reset, and count+inflight<QDEPTH.
  - count is the registered queue occupancy. The check is conservative; a same-cycle pop is ignored.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (speculative sequential).
- Response: when inflight=1, imem_data_pyri is the word for inflight_pc. It is always enqueued as {inflight_pc, data}. Predecode on op=data[6:0]:
  - OP_JAL: fetch_pc<=inflight_pc+sext({d[31],d[19:12],d[20],d[30:21],1'b0}). Squash any request issued this cycle (its response is dropped).
  - OP_BRANCH or OP_JALR: state<=BR_WAIT. Squash any request issued this cycle.
  - Other ops: no action.
- Squash: a squashed response is not enqueued and not predecoded. inflight_pc of the squashed request is discarded.
- BR_WAIT:
  - No requests are issued.
  - Queue drains normally.
  - branch_pc_valid_pyri=1 → fetch_pc<=branch_pc_pyri, state<=RUN, queue kept. The first new request goes out the next cycle.
- Redirect in RUN (branch_pc_valid_pyri=1 while state==RUN):
  - Treated as flush: queue emptied, inflight squashed, fetch_pc<=branch_pc_pyri.
  - Flush wins over a same-cycle enqueue or pop.
- Dequeue:
  - Head pops when valid && !(pc_retry_pyri | inst_retry_pyri). Both retries are honoured jointly.
  - Head data holds stable while retried.
- Same-cycle enqueue+pop: count unchanged; pointers wrap modulo QDEPTH.
- Full queue: no issue. Because of the credit check, a response never arrives at a full queue.
- PC arithmetic: XLEN-bit two's complement, wraps silently. Alignment is not checked.
- Reset mid-operation: reset dominates all events. An in-flight response in the cycle after reset is ignored.
- Latency: reset deassert → first imem_req next cycle → first pc_valid_pyro 2 cycles after the request. Steady state: 1 instruction/cycle.

Optional Feature:
PYRM_FETCH_PERF_CNT_EN:
- When defined, adds outputs fetched_cnt_pyro (64) and br_stall_cnt_pyro (64), both cleared on reset.
  - fetched_cnt_pyro increments per dequeued instruction.
  - br_stall_cnt_pyro increments every cycle state==BR_WAIT.
  - Both saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset with memory all 0x00000013, no retries → requests at 0x80000000, 0x80000004, ...; pc_pyro 0x80000000 first valid 2 cycles after reset release, then +4 every cycle.
- 0x0100006F (jal x0,16) at 0x80000008 → 0x8000000C response dropped; next enqueued pc 0x80000018; queue never holds 0x8000000C.
- 0x00000063 at 0x80000004, branch_pc_pyri=0x80000100 presented 5 cycles later → no requests in BR_WAIT; next queued pc after 0x80000004 is 0x80000100.
- Hold inst_retry_pyri=1 for 10 cycles from reset → occupancy stops at QDEPTH=4, imem_req_pyro=0, head stays 0x80000000; release → 0x80000000..0x8000000C drain in order with no loss.
- Redirect to 0x80000200 in RUN with queue holding 3 entries → valids drop next cycle; next output pc 0x80000200; stale response not enqueued.
- Assert reset_pyri while in BR_WAIT with a full queue → next cycle queue empty, state RUN, request at 0x80000000.
